// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative read-only cache with true-LRU
// replacement, valid/ready request port and word-serial refill port.
module set_assoc_cache #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 16,
    parameter int unsigned WORDS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic [31:0]       access_count,
    output logic [31:0]       hit_count
);
    localparam int unsigned WORD_W = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WA_W   = ADDR_W - 2;
    localparam int unsigned TAG_W  = WA_W - WORD_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_e;

    state_e            state_q, state_d;
    logic [WA_W-1:0]   waddr_q, waddr_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q, resp_hit_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       access_q, access_d;
    logic [31:0]       hits_q, hits_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]  tag_d   [SETS][WAYS];
    logic [WAY_W-1:0]  age_q   [SETS][WAYS];
    logic [WAY_W-1:0]  age_d   [SETS][WAYS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];

    logic [WORD_W-1:0] word_c;
    logic [IDX_W-1:0]  idx_c;
    logic [TAG_W-1:0]  tag_c;
    logic              hit_c;
    logic [WAY_W-1:0]  hit_way_c;
    logic [WAY_W-1:0]  victim_c;
    logic              data_we_c;
    logic              touch_en_c;
    logic [WAY_W-1:0]  touch_way_c;
    logic              unused_byte_c;

    assign word_c        = waddr_q[WORD_W-1:0];
    assign idx_c         = waddr_q[WORD_W +: IDX_W];
    assign tag_c         = waddr_q[WORD_W+IDX_W +: TAG_W];
    assign unused_byte_c = ^req_addr[1:0];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Tag match across the set, and victim choice: lowest invalid way, else the LRU way
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (age_q[idx_c][w] == WAY_W'(WAYS - 1)) begin
                victim_c = WAY_W'(w);
            end
        end
        for (int unsigned k = 0; k < WAYS; k++) begin
            if (!valid_q[idx_c][WAYS-1-k]) begin
                victim_c = WAY_W'(WAYS - 1 - k);
            end
        end
    end

    // Next-state, response, refill and LRU bookkeeping
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        victim_d     = victim_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_data_d  = resp_data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        access_d     = access_q;
        hits_d       = hits_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        age_d        = age_q;
        data_we_c    = 1'b0;
        touch_en_c   = 1'b0;
        touch_way_c  = '0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    waddr_d = req_addr[ADDR_W-1:2];
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                access_d = sat_inc(access_q);
                if (hit_c) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_data_d  = data_q[idx_c][hit_way_c][word_c];
                    hits_d       = sat_inc(hits_q);
                    touch_en_c   = 1'b1;
                    touch_way_c  = hit_way_c;
                    state_d      = IDLE;
                end else begin
                    victim_d   = victim_c;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {tag_c, idx_c, WORD_W'(0), 2'b00};
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    data_we_c = 1'b1;
                    if (cnt_q == WORD_W'(WORDS - 1)) begin
                        valid_d[idx_c][victim_q] = 1'b1;
                        tag_d[idx_c][victim_q]   = tag_c;
                        touch_en_c   = 1'b1;
                        touch_way_c  = victim_q;
                        resp_valid_d = 1'b1;
                        resp_hit_d   = 1'b0;
                        // earlier words are already in the array; the last one is still on the bus
                        resp_data_d  = (word_c == cnt_q) ? mem_data : data_q[idx_c][victim_q][word_c];
                        mem_req_d    = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        cnt_d      = cnt_q + WORD_W'(1);
                        mem_addr_d = {tag_c, idx_c, cnt_q + WORD_W'(1), 2'b00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Ages younger than the touched way grow by one; touched way becomes MRU
        if (touch_en_c) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[idx_c][w] < age_q[idx_c][touch_way_c]) begin
                    age_d[idx_c][w] = age_q[idx_c][w] + WAY_W'(1);
                end
            end
            age_d[idx_c][touch_way_c] = '0;
        end

        req_ready_d = (state_d == IDLE);
    end

    // Control, tag and LRU state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            victim_q     <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            access_q     <= '0;
            hits_q       <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    tag_q[s][w] <= '0;
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            victim_q     <= victim_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_data_q  <= resp_data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            access_q     <= access_d;
            hits_q       <= hits_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            age_q        <= age_d;
        end
    end

    // Line data array; contents survive reset since valid bits gate their use
    always_ff @(posedge clk) begin
        if (!rst && data_we_c) begin
            data_q[idx_c][victim_q][cnt_q] <= mem_data;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_hit_q;
    assign resp_data    = resp_data_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign access_count = access_q;
    assign hit_count    = hits_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache with an MRU-ordered tag-list reference model.
module tb_set_assoc_cache;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WAYS   = 2;
    localparam int unsigned SETS   = 16;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned LINE_B = 4 * WORDS;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_hit;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic [31:0]       access_count;
    logic [31:0]       hit_count;

    set_assoc_cache #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .access_count(access_count), .hit_count(hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        logic [31:0] data;
        int unsigned acc;
        int unsigned hits;
        int unsigned acc_cyc;
        int unsigned lat;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned mon_lat;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          mode = 0;      // 0: word per cycle, 1: random mem_valid, 2: 5-cycle gaps
    int          beats = 0;
    int          gap = 0;
    bit          refill_active = 1'b0;
    logic [31:0] cur_addr = '0;

    // Reference model: per set, resident tags ordered MRU first
    int unsigned m_tag [SETS][WAYS];
    int unsigned m_n   [SETS];
    int unsigned m_acc, m_hit;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) m_n[s] = 0;
        m_acc = 0;
        m_hit = 0;
    endfunction

    function automatic bit model_access(input logic [31:0] a);
        int unsigned s;
        int unsigned t;
        int          pos;
        bit          hit;
        s   = (a / LINE_B) % SETS;
        t   = a / (LINE_B * SETS);
        pos = -1;
        for (int i = 0; i < int'(m_n[s]); i++) if (m_tag[s][i] == t) pos = i;
        hit = (pos >= 0);
        if (!hit) begin
            if (m_n[s] < WAYS) m_n[s]++;
            pos = int'(m_n[s]) - 1;   // a full set drops its least recently used tag
        end
        for (int i = pos; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
        m_tag[s][0] = t;
        if (m_acc != 32'hFFFF_FFFF) m_acc++;
        if (hit && m_hit != 32'hFFFF_FFFF) m_hit++;
        return hit;
    endfunction

    // Issue one read; lat is the exact miss latency in edges after acceptance, 0 = lower bound only
    task automatic do_access(input logic [31:0] a, input int unsigned lat);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(req_ready), 32'd1);
        cur_addr  = a;
        e.hit     = model_access(a);
        e.data    = a & ~32'h3;
        e.acc     = m_acc;
        e.hits    = m_hit;
        e.acc_cyc = cyc;
        e.lat     = e.hit ? 1 : lat;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Memory responder and response monitor
    always @(negedge clk) begin
        if (mem_req) begin
            refill_active = 1'b1;
            chk("mem_addr", mem_addr, (cur_addr & ~32'(LINE_B - 1)) + 32'(beats * 4));
            if (gap > 0) begin
                mem_valid = 1'b0;
                gap--;
            end else if (mode == 1 && $urandom_range(0, 1) == 0) begin
                mem_valid = 1'b0;
            end else begin
                mem_valid = 1'b1;
                mem_data  = mem_addr;
                beats++;
                gap = (mode == 2) ? 5 : 0;
            end
        end else begin
            gap       = 0;
            mem_valid = 1'($urandom_range(0, 1));  // stray beats outside refill must be ignored
            mem_data  = $urandom;
            if (refill_active && !resp_valid && !rst) begin
                checks++;
                errors++;
                $display("FAIL mem_req_drop actual=0 expected=1");
                refill_active = 1'b0;
            end
        end

        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=%h expected=none", resp_data);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_lat = cyc - mon_e.acc_cyc - 1;
                chk("resp_hit", 32'(resp_hit), 32'(mon_e.hit));
                chk("resp_data", resp_data, mon_e.data);
                chk("access_count", access_count, mon_e.acc);
                chk("hit_count", hit_count, mon_e.hits);
                chk("refill_beats", 32'(beats), mon_e.hit ? 32'd0 : 32'(WORDS));
                chk("mem_req_seen", 32'(refill_active), 32'(!mon_e.hit));
                if (mon_e.lat != 0) begin
                    chk("latency", mon_lat, mon_e.lat);
                end else begin
                    chk("latency_min", 32'(mon_lat >= WORDS + 1), 32'd1);
                end
            end
            beats         = 0;
            refill_active = 1'b0;
            gap           = 0;
        end

        if (rst) begin
            exp_q.delete();
            beats         = 0;
            refill_active = 1'b0;
            gap           = 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] a;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_access", access_count, 32'd0);
        chk("rst_hits", hit_count, 32'd0);

        // cold miss then hit in the same line
        mode = 0;
        do_access(32'h0000_0040, WORDS + 1);
        do_access(32'h0000_0048, 1);
        wait_drain();

        // LRU eviction in set 0
        do_access(32'h000, WORDS + 1);
        do_access(32'h100, WORDS + 1);
        do_access(32'h000, 1);
        do_access(32'h200, WORDS + 1);
        do_access(32'h000, 1);
        do_access(32'h100, WORDS + 1);
        wait_drain();

        // memory stalls of 5 cycles between refill words
        mode = 2;
        do_access(32'h0000_1044, WORDS + 1 + 5 * (WORDS - 1));
        wait_drain();
        mode = 0;
        do_access(32'h0000_104C, 1);
        wait_drain();

        // reset after the second refill word
        do_access(32'h0000_03C8, 0);
        n = 0;
        while (beats < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("midrefill_beats", 32'(beats >= 2), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrefill_mem_req", 32'(mem_req), 32'd0);
        chk("midrefill_resp", 32'(resp_valid), 32'd0);
        chk("midrefill_access", access_count, 32'd0);
        chk("midrefill_hits", hit_count, 32'd0);
        repeat (3) @(negedge clk);
        chk("midrefill_resp_late", 32'(resp_valid), 32'd0);
        do_access(32'h0000_03C8, WORDS + 1);
        wait_drain();

        // reset beats a simultaneous request
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0080;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rstreq_access", access_count, 32'd0);
        chk("rstreq_mem_req", 32'(mem_req), 32'd0);
        chk("rstreq_ready", 32'(req_ready), 32'd1);

        // random trace over a small footprint so sets fill and evict
        mode = 1;
        for (int i = 0; i < 1000; i++) begin
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | 32'($urandom_range(0, 15));
            do_access(a, 0);
        end
        wait_drain();
        repeat (3) @(negedge clk);

        chk("final_access", access_count, m_acc);
        chk("final_hits", hit_count, m_hit);
        chk("hits_le_access", 32'(hit_count <= access_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative, read-only cache with true-LRU replacement, a valid/ready request port, and a word-serial refill port toward backing memory. It supersedes the direct-mapped cache in the trace-driven cache-evaluation flow: the trace bench drives `req_addr`, and the block reports per-access hit/miss plus running access and hit counters for hit-rate computation.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: word width; must be 32. Byte offset = low 2 address bits, ignored.
- `WAYS`, default 2: associativity; power of two, 1..8.
- `SETS`, default 16: number of sets; power of two, ≥2.
- `WORDS`, default 4: words per line; power of two, ≥2.
- `clk` in 1: single clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_addr` in ADDR_W: byte address of the requested word.
- `resp_valid` out 1: one-cycle pulse; response fields valid.
- `resp_data` out DATA_W: requested word.
- `resp_hit` out 1: 1 = hit, 0 = miss (served after refill).
- `mem_req` out 1: refill word request, held until `mem_valid`.
- `mem_addr` out ADDR_W: word-aligned byte address of the refill word; low 2 bits are 0.
- `mem_valid` in 1: `mem_data` valid; completes the current refill word.
- `mem_data` in DATA_W: refill word.
- `access_count` out 32: resolved lookups, saturating.
- `hit_count` out 32: resolved hits, saturating.

## Operation
- Address split, LSB first: 2 byte bits, log2(WORDS) word bits, log2(SETS) index bits, remaining bits tag.
- Storage per set and way: valid bit, tag, WORDS data words, and a log2(WAYS)-bit age. Age 0 is most-recently used.
- FSM states: IDLE, LOOKUP, REFILL.
- IDLE: `req_ready`=1. On `req_valid`, the address is registered and the FSM moves to LOOKUP. Otherwise it stays in IDLE.
- LOOKUP: `req_ready`=0. Compare the tag against all valid ways of the set.
  - Hit: register `resp_valid`=1, `resp_hit`=1, and `resp_data`. Update LRU. Increment both counters. Go to IDLE.
  - Miss: select the victim and increment `access_count`. Set word counter = 0. Go to REFILL.
- Victim selection: the lowest-index invalid way. If all ways are valid, the way with age WAYS-1.
- REFILL: `mem_req`=1, `mem_addr` = {tag, index, word counter, 2'b00}.
  - Each `mem_valid` writes `mem_data` into the victim way at the counter position, then increments the counter.
  - `mem_req` stays high between words; it is low only outside REFILL.
  - On the last word (counter = WORDS-1 with `mem_valid`): set valid, write the tag, and update LRU. Register `resp_valid`=1, `resp_hit`=0, and `resp_data` = the requested word (taken from `mem_data` if it is the last word). Go to IDLE.
- LRU update on access to way w: every way in the set with age < age[w] increments its age; age[w] becomes 0. Ages in a set are always a permutation of 0..WAYS-1.
- Counters stop at 32'hFFFF_FFFF; `hit_count` ≤ `access_count` always.
- Reset:
  - clears all valid bits;
  - sets ages to the way index (way 0 is MRU);
  - FSM goes to IDLE and the counters go to 0;
  - `resp_valid`, `resp_hit`, and `mem_req` go to 0; `resp_data` and `mem_addr` go to 0.
- Data arrays are not cleared by reset.

## Timing
- Request accepted at edge E0 (`req_valid` and `req_ready` both 1).
- Hit: `resp_valid` is high for exactly the one cycle following E1, and `req_ready` is 1 in that same cycle. Peak throughput is one request per 2 cycles.
- Miss: `mem_req` rises in the cycle after E1. Response is registered at the edge that samples the final `mem_valid`. Minimum miss latency = WORDS+1 edges after E0.
- `req_valid` while `req_ready`=0: ignored. The requester holds its request.
- `mem_valid` outside REFILL: ignored. `mem_valid` high every cycle gives one word per cycle.
- `rst` during REFILL: the refill is abandoned with no response and no valid line. `mem_req` is 0 the cycle after the reset edge.
- `rst` together with `req_valid` in IDLE: reset wins and the request is not accepted.

## Test plan
- Cold miss, defaults: read 0x0000_0040 with memory returning data = address.
  - Expect `mem_addr` 0x40, 0x44, 0x48, 0x4C.
  - Expect `resp_hit`=0, `resp_data`=0x40, counters 1/0.
- Hit: then read 0x0000_0048. Expect `resp_valid` in the 2nd cycle after acceptance, `resp_hit`=1, `resp_data`=0x48, counters 2/1, and no `mem_req`.
- LRU, WAYS=2 (all addresses map to set 0): read 0x000, 0x100, then 0x000 again, then 0x200.
  - The read of 0x200 evicts the 0x100 line.
  - A following read of 0x000 hits and a read of 0x100 misses.
- Memory stall: hold `mem_valid` low for 5 cycles between refill words. `mem_req` and `mem_addr` must stay stable, and the response arrives only after the 4th word.
- Reset mid-refill: assert `rst` after the 2nd refill word.
  - Expect `mem_req`=0 next cycle, no `resp_valid`, and counters 0.
  - A re-read of the same address misses.
- Trace replay: 1000 random addresses compared against a reference model of tags, LRU, and counters. Require exact `resp_hit` and `resp_data` per access and final counters equal to the model.
